// File: rtl/ysyx_22040365_mcore.sv
// Multi-cycle RV64I subset core: FETCH/EXEC/WB sequencing over a valid-qualified
// instruction fetch, with halt on ebreak or illegal instruction.
module ysyx_22040365_mcore #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  pc,
  output logic             dbg_wen,
  output logic [4:0]       dbg_waddr,
  output logic [XLEN-1:0]  dbg_wdata,
  output logic [CNT_W-1:0] retired,
  output logic             halt,
  output logic             halt_illegal,
  output logic [XLEN-1:0]  exit_code
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;

  state_t            state;
  logic [31:0]       ir;
  logic [XLEN-1:0]   next_pc_q;
  logic [XLEN-1:0]   rf [32];

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [XLEN-1:0]   rs1_val, rs2_val, imm_i, imm_u, imm_j, pc_plus4;
  logic [XLEN-1:0]   result, next_pc;
  logic              is_ebreak, is_illegal;

  assign imem_addr = pc;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign rs1_val  = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign imm_i    = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_u    = {{(XLEN-32){ir[31]}}, ir[31:12], 12'b0};
  assign imm_j    = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign pc_plus4 = pc + XLEN'(4);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    result     = '0;
    next_pc    = pc_plus4;
    is_illegal = 1'b0;
    is_ebreak  = (ir == EBREAK);
    if (!is_ebreak) begin
      case (opcode)
        OP_IMM: begin
          if (funct3 == 3'b000) result = rs1_val + imm_i;
          else                  is_illegal = 1'b1;
        end
        OP_REG: begin
          if (funct3 == 3'b000 && funct7 == 7'h00)      result = rs1_val + rs2_val;
          else if (funct3 == 3'b000 && funct7 == 7'h20) result = rs1_val - rs2_val;
          else                                          is_illegal = 1'b1;
        end
        OP_LUI:   result = imm_u;
        OP_AUIPC: result = pc + imm_u;
        OP_JAL: begin
          result  = pc_plus4;
          next_pc = pc + imm_j;
        end
        OP_JALR: begin
          if (funct3 == 3'b000) begin
            result  = pc_plus4;
            next_pc = (rs1_val + imm_i) & ~XLEN'(1);
          end else begin
            is_illegal = 1'b1;
          end
        end
        default: is_illegal = 1'b1;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      ir           <= '0;
      next_pc_q    <= '0;
      retired      <= '0;
      imem_req     <= 1'b1;
      halt         <= 1'b0;
      halt_illegal <= 1'b0;
      exit_code    <= '0;
      dbg_wen      <= 1'b0;
      dbg_waddr    <= '0;
      dbg_wdata    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_ebreak || is_illegal) begin
            state        <= S_HALT;
            halt         <= 1'b1;
            halt_illegal <= is_illegal;
            exit_code    <= rf[10];
            if (is_ebreak) retired <= retired + CNT_W'(1);
          end else begin
            // Every supported instruction writes rd; x0 writes are suppressed here.
            state     <= S_WB;
            dbg_wen   <= (rd != 5'd0);
            dbg_waddr <= rd;
            dbg_wdata <= result;
            next_pc_q <= next_pc;
          end
        end
        S_WB: begin
          pc        <= next_pc_q;
          retired   <= retired + CNT_W'(1);
          dbg_wen   <= 1'b0;
          dbg_waddr <= '0;
          dbg_wdata <= '0;
          imem_req  <= 1'b1;
          state     <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the register file is deliberately left unreset so it maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (!rst && state == S_WB && dbg_wen) rf[dbg_waddr] <= dbg_wdata;
  end

endmodule

// File: tb/tb_ysyx_22040365_mcore.sv
// Self-checking bench for ysyx_22040365_mcore against an ISA-level reference model.
module tb_ysyx_22040365_mcore;

  localparam int          XLEN     = 64;
  localparam int          CNT_W    = 32;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_valid;
  logic [31:0]      imem_rdata;
  logic [XLEN-1:0]  pc;
  logic             dbg_wen;
  logic [4:0]       dbg_waddr;
  logic [XLEN-1:0]  dbg_wdata;
  logic [CNT_W-1:0] retired;
  logic             halt;
  logic             halt_illegal;
  logic [XLEN-1:0]  exit_code;

  ysyx_22040365_mcore #(.XLEN(XLEN), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .pc(pc),
    .dbg_wen(dbg_wen), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .retired(retired), .halt(halt), .halt_illegal(halt_illegal), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Architectural reference state
  logic [63:0] m_x [32];
  logic [63:0] m_pc;
  logic [31:0] m_ret;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // ISA semantics of one instruction at m_pc; does not commit state.
  task automatic model_exec(input logic [31:0] w, output bit ill, output bit ebr,
                            output logic [4:0] rd, output logic [63:0] val,
                            output logic [63:0] npc);
    logic [63:0] a, b, immi, immu, immj;
    a    = m_x[w[19:15]];
    b    = m_x[w[24:20]];
    immi = longint'($signed(w[31:20]));
    immu = longint'($signed({w[31:12], 12'h000}));
    immj = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    rd   = w[11:7];
    val  = 64'd0;
    npc  = m_pc + 64'd4;
    ill  = 1'b0;
    ebr  = (w == 32'h0010_0073);
    if (!ebr) begin
      case (w[6:0])
        7'h13: if (w[14:12] == 3'd0) val = a + immi; else ill = 1'b1;
        7'h33: begin
          if (w[14:12] == 3'd0 && w[31:25] == 7'h00)      val = a + b;
          else if (w[14:12] == 3'd0 && w[31:25] == 7'h20) val = a - b;
          else                                            ill = 1'b1;
        end
        7'h37: val = immu;
        7'h17: val = m_pc + immu;
        7'h6f: begin val = m_pc + 64'd4; npc = m_pc + immj; end
        7'h67: begin
          if (w[14:12] == 3'd0) begin
            val = m_pc + 64'd4;
            npc = (a + immi) & ~64'd1;
          end else ill = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = $urandom;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    imem_valid = 1'b0;
    m_pc       = RESET_PC;
    m_ret      = '0;
  endtask

  task automatic check_reset_state();
    total++;
    if (pc !== RESET_PC || retired !== 0 || halt !== 0 || halt_illegal !== 0 ||
        exit_code !== 0 || dbg_wen !== 0 || dbg_waddr !== 0 || dbg_wdata !== 0 ||
        imem_req !== 1)
      begin
        bad++;
        $display("FAIL reset_state: pc=%h ret=%0d halt=%b ill=%b exit=%h wen=%b wa=%0d wd=%h req=%b want pc=%h others 0 req=1",
                 pc, retired, halt, halt_illegal, exit_code, dbg_wen, dbg_waddr, dbg_wdata, imem_req, RESET_PC);
      end
  endtask

  // Entered at a negedge inside a FETCH cycle; returns at the next FETCH or in HALT.
  task automatic run_instr(input logic [31:0] w, input int stall);
    logic [63:0] pc0, val, npc;
    logic [4:0]  rd;
    bit          ill, ebr;
    pc0 = m_pc;
    for (int c = 0; c <= stall; c++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== pc0) begin
        bad++;
        $display("FAIL fetch_req: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, pc0);
      end
      imem_valid = (c == stall);
      imem_rdata = (c == stall) ? w : $urandom;
      @(negedge clk);
    end
    imem_valid = 1'($urandom);
    imem_rdata = $urandom;
    model_exec(w, ill, ebr, rd, val, npc);
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL exec_req: req=%b want 0", imem_req);
    end
    @(negedge clk);
    if (ill || ebr) begin
      if (ebr) m_ret++;
      total++;
      if (halt !== 1'b1 || halt_illegal !== ill || exit_code !== m_x[10] ||
          retired !== m_ret || pc !== pc0 || imem_req !== 1'b0 || dbg_wen !== 1'b0) begin
        bad++;
        $display("FAIL halt_entry: halt=%b ill=%b exit=%h ret=%0d pc=%h req=%b wen=%b want 1 %b %h %0d %h 0 0",
                 halt, halt_illegal, exit_code, retired, pc, imem_req, dbg_wen, ill, m_x[10], m_ret, pc0);
      end
    end else begin
      total++;
      if (dbg_wen !== (rd != 5'd0)) begin
        bad++;
        $display("FAIL wb_wen: got %b want %b (word %h)", dbg_wen, (rd != 5'd0), w);
      end
      if (rd != 5'd0) begin
        total++;
        if (dbg_waddr !== rd || dbg_wdata !== val) begin
          bad++;
          $display("FAIL wb_data: got x%0d=%h want x%0d=%h (word %h)", dbg_waddr, dbg_wdata, rd, val, w);
        end
        m_x[rd] = val;
      end
      m_pc = npc;
      m_ret++;
      @(negedge clk);
      total++;
      if (pc !== m_pc || retired !== m_ret || halt !== 1'b0) begin
        bad++;
        $display("FAIL after_wb: pc=%h ret=%0d halt=%b want pc=%h ret=%0d halt=0", pc, retired, halt, m_pc, m_ret);
      end
    end
    imem_valid = 1'b0;
  endtask

  task automatic hold_halt(input int n);
    for (int c = 0; c < n; c++) begin
      imem_valid = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk);
      total++;
      if (imem_req !== 0 || halt !== 1 || pc !== m_pc || retired !== m_ret || dbg_wen !== 0) begin
        bad++;
        $display("FAIL halt_hold: req=%b halt=%b pc=%h ret=%0d wen=%b want 0 1 %h %0d 0",
                 imem_req, halt, pc, retired, dbg_wen, m_pc, m_ret);
      end
    end
    imem_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_state();
  endtask

  task automatic test_addi();
    run_instr(32'h0050_0093, 0);
  endtask

  task automatic test_arith();
    run_instr(enc_i(7'h13, 5'd1, 5'd0, 12'hFFF), 0);
    run_instr(enc_r(7'h00, 5'd2, 5'd1, 5'd1), 1);
    run_instr(enc_r(7'h20, 5'd3, 5'd2, 5'd1), 0);
    run_instr(enc_i(7'h13, 5'd0, 5'd0, 12'd7), 0);
    run_instr(enc_r(7'h00, 5'd4, 5'd0, 5'd3), 0);
  endtask

  task automatic test_upper();
    do_reset();
    run_instr(enc_u(7'h37, 5'd5, 20'h80000), 0);
    run_instr(enc_i(7'h13, 5'd0, 5'd0, 12'd0), 0);
    run_instr(enc_u(7'h17, 5'd6, 20'h00001), 0);
  endtask

  task automatic test_jump();
    do_reset();
    run_instr(enc_j(5'd1, 21'd8), 0);
    run_instr(enc_i(7'h67, 5'd0, 5'd1, 12'd0), 0);
    run_instr(enc_i(7'h67, 5'd1, 5'd1, 12'h7FD), 0);
  endtask

  task automatic test_stall();
    run_instr(enc_i(7'h13, 5'd4, 5'd0, 12'd3), 4);
  endtask

  task automatic test_halt();
    do_reset();
    run_instr(enc_i(7'h13, 5'd10, 5'd0, 12'd42), 0);
    run_instr(32'h0010_0073, 0);
    hold_halt(4);
    do_reset();
    check_reset_state();
  endtask

  task automatic test_illegal();
    logic [31:0] words [6];
    words[0] = 32'hFFFF_FFFF;
    words[1] = 32'h0000_0000;
    words[2] = {12'd0, 5'd1, 3'b001, 5'd2, 7'h13};
    words[3] = {7'h01, 5'd1, 5'd1, 3'b000, 5'd2, 7'h33};
    words[4] = {12'd0, 5'd1, 3'b001, 5'd2, 7'h67};
    words[5] = {12'd0, 5'd1, 3'b011, 5'd2, 7'h03};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_instr(enc_i(7'h13, 5'd10, 5'd0, 12'(i + 7)), 0);
      run_instr(words[i], i % 2);
      hold_halt(2);
    end
  endtask

  task automatic test_rst_fetch();
    do_reset();
    run_instr(enc_i(7'h13, 5'd7, 5'd0, 12'd1), 0);
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = enc_i(7'h13, 5'd7, 5'd0, 12'd9);
    @(negedge clk);
    rst        = 1'b0;
    imem_valid = 1'b0;
    m_pc       = RESET_PC;
    m_ret      = '0;
    check_reset_state();
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL rst_fetch_hold: req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [4:0]  rd, ra, rb;
    logic [11:0] imm12;
    logic [19:0] imm20;
    logic [20:0] imm21;
    do_reset();
    for (int r = 1; r < 32; r++)
      run_instr(enc_i(7'h13, 5'(r), 5'd0, 12'($urandom)), 0);
    for (int n = 0; n < 100; n++) begin
      rd    = 5'($urandom);
      ra    = 5'($urandom);
      rb    = 5'($urandom);
      imm12 = 12'($urandom);
      imm20 = 20'($urandom);
      imm21 = 21'($urandom) & ~21'd1;
      case ($urandom_range(0, 6))
        0: run_instr(enc_i(7'h13, rd, ra, imm12), $urandom_range(0, 2));
        1: run_instr(enc_r(7'h00, rd, ra, rb), $urandom_range(0, 2));
        2: run_instr(enc_r(7'h20, rd, ra, rb), $urandom_range(0, 2));
        3: run_instr(enc_u(7'h37, rd, imm20), $urandom_range(0, 2));
        4: run_instr(enc_u(7'h17, rd, imm20), $urandom_range(0, 2));
        5: run_instr(enc_j(rd, imm21), $urandom_range(0, 2));
        default: run_instr(enc_i(7'h67, rd, ra, imm12), $urandom_range(0, 2));
      endcase
    end
    run_instr(32'h0010_0073, 1);
    hold_halt(2);
  endtask

  initial begin
    rst        = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = '0;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    m_pc  = RESET_PC;
    m_ret = '0;
    test_reset();
    test_addi();
    test_arith();
    test_upper();
    test_jump();
    test_stall();
    test_halt();
    test_illegal();
    test_rst_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
